fan_tach_emulator: RTL and testbench
====================================

Name: fan_tach_emulator

Overview:
Board-side model of a 4-wire PWM fan: samples the fan PWM drive, measures its duty cycle, ramps an internal speed toward it, and generates a tachometer square wave whose frequency is proportional to speed. Used on boards without a fitted fan and in system simulation, with `tach_out` looped to the fan-tach input of the fan controller. It is the responder for the PWM-out / tach-in fan controller and runs on the same host clock.

Parameters:
- PWM_BITS, 10, PWM period is 2^PWM_BITS clocks; FULL = 2^PWM_BITS.
- PHASE_BITS, 24, width of the tach NCO phase accumulator.
- INC_SHIFT, 0, NCO increment = speed << INC_SHIFT.
- RAMP_DIV, 4096, clocks per 1-LSB speed step (>=1).

Ports:
- clock  in  1  host clock.
- reset  in  1  asynchronous, active-high reset.
- pwm_in  in  1  fan PWM drive.
- tach_out  out  1  emulated tach square wave.
- duty_meas  out  PWM_BITS+1  last measured high count, 0..FULL.
- duty_valid  out  1  one-cycle pulse when duty_meas updates.
- speed  out  PWM_BITS+1  current emulated speed, 0..FULL.

Behaviour:
- Reset values (async, active-high): every register 0. `tach_out`=0, `duty_meas`=0, `duty_valid`=0, `speed`=0, phase=0, armed=0. Synchronizer flops are also 0.
- Input conditioning: `pwm_in` passes a 2-flop synchronizer giving `pwm_s`, then one more register `pwm_d`. A rising edge is `pwm_s & ~pwm_d`.
- high_cnt and win_cnt restart on every rising edge and on timeout.
  - high_cnt counts cycles with `pwm_s`=1. It saturates at FULL.
  - win_cnt counts all cycles. It saturates at 2*FULL.
- Rising edge with armed=1:
  - `duty_meas` <= high_cnt (the previous window, excluding the current cycle).
  - `duty_valid`=1 for that cycle.
  - high_cnt <= 1, win_cnt <= 1.
- Rising edge with armed=0: armed <= 1, counters restart as above, no update.
- Timeout: win_cnt reaching 2*FULL with no rising edge.
  - `duty_meas` <= (`pwm_s` ? FULL : 0) and `duty_valid` pulses.
  - armed <= 0, counters restart at 0.
  - A constant level therefore repeats the timeout every 2*FULL cycles.
- Simultaneous rising edge and timeout: the rising edge wins.
- Window longer than FULL cycles: the result is the high count, saturated at FULL. Period is not normalised.
- Speed ramp:
  - A divider counts 0..RAMP_DIV-1; the terminal count is a ramp tick.
  - On a tick, `speed` moves 1 toward `duty_meas` (+1 if below, -1 if above, hold if equal).
  - RAMP_DIV=1 gives a tick every cycle.
  - A `duty_meas` update on a tick cycle: the ramp compares against the old value.
- Tach NCO:
  - Each cycle, phase <= phase + (`speed` << INC_SHIFT), modulo 2^PHASE_BITS.
  - A carry out toggles `tach_out` in the same cycle the phase registers.
  - `speed`=0: phase is frozen and `tach_out` holds its level.
  - tach frequency = f_clk * (`speed` << INC_SHIFT) / 2^(PHASE_BITS+1).
- Latency: `pwm_in` edge to the `duty_valid` pulse is 3 clocks.
- Reset mid-operation: everything returns to reset values immediately. The first post-reset rising edge only arms.

Optional Feature:
- FAN_EMU_STALL_EN defined:
  - Adds input port `stall` (1 bit, after `pwm_in`) that models a seized rotor.
  - While `stall`=1, the ramp target is 0 instead of `duty_meas`, so speed decays at the normal ramp rate. Phase is frozen and `tach_out` holds.
  - Duty measurement continues unaffected.
  - On deassertion, `speed` ramps from its current value back toward `duty_meas`.
- Not defined: no `stall` port; the target is always `duty_meas`.

Test Plan (PWM_BITS=4, PHASE_BITS=8, INC_SHIFT=0, RAMP_DIV=1 unless noted):
- Reset, `pwm_in`=0 -> all outputs 0. After 32 cycles `duty_valid` pulses with `duty_meas`=0, repeating every 32 cycles. `tach_out` stays 0.
- `pwm_in` 8 high / 8 low, period 16:
  - First `duty_valid` comes at the second rising edge + 3 clocks, with `duty_meas`=8.
  - `speed` reaches 8 eight cycles later.
  - `tach_out` then toggles every 32 cycles (period 64).
- Duty changes 8 -> 4 (4 high / 12 low) -> next `duty_valid` gives `duty_meas`=4. `speed` steps down 1/cycle to 4. Tach period becomes 128.
- `pwm_in` held 1 -> timeout gives `duty_meas`=16 and `speed`=16, tach period 32. A rising edge arriving in the same cycle as the timeout takes precedence (window latched, no FULL).
- RAMP_DIV=4, `duty_meas` from 0 to 12 -> `speed` increments once every 4 cycles, reaching 12 after 48 cycles. Async reset mid-ramp -> `speed`, `tach_out`, phase are 0 immediately.
- FAN_EMU_STALL_EN, `speed`=8, `stall`=1 -> `tach_out` frozen, `speed` falls to 0 in 8 cycles, `duty_valid` continues. `stall`=0 -> `speed` returns to 8 in 8 cycles and tach resumes.

Source files
------------

// File: rtl/fan_tach_emulator.sv
// fan_tach_emulator: emulated 4-wire fan. It measures the PWM duty, ramps a speed toward it and drives an NCO tach output.
// Optional build macro FAN_EMU_STALL_EN adds a `stall` input that models a seized rotor.
module fan_tach_emulator #(
  parameter int unsigned PWM_BITS   = 10,
  parameter int unsigned PHASE_BITS = 24,
  parameter int unsigned INC_SHIFT  = 0,
  parameter int unsigned RAMP_DIV   = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pwm_in,
`ifdef FAN_EMU_STALL_EN
  input  logic                stall,
`endif
  output logic                tach_out,
  output logic [PWM_BITS:0]   duty_meas,
  output logic                duty_valid,
  output logic [PWM_BITS:0]   speed
);

  localparam int unsigned DW    = PWM_BITS + 1;
  localparam int unsigned WW    = PWM_BITS + 2;
  localparam int unsigned PW    = PHASE_BITS + 1;
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [DW-1:0]    FULL_V   = DW'(1) << PWM_BITS;
  localparam logic [WW-1:0]    WIN_MAX  = WW'(2) << PWM_BITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic                  pwm_meta;
  logic                  pwm_s;
  logic                  pwm_d;
  logic                  rise;
  logic                  timeout;
  logic                  armed;
  logic [DW-1:0]         high_cnt;
  logic [DW-1:0]         high_nxt;
  logic [WW-1:0]         win_cnt;
  logic [WW-1:0]         win_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  ramp_tick;
  logic                  frozen;
  logic [DW-1:0]         target;
  logic [PHASE_BITS-1:0] phase;
  logic [PW-1:0]         phase_inc;
  logic [PW-1:0]         phase_sum;

  // Input synchronizer plus one delay stage for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_meta <= 1'b0;
      pwm_s    <= 1'b0;
      pwm_d    <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_s    <= pwm_meta;
      pwm_d    <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;

  // Saturating window counters
  always_comb begin
    high_nxt = high_cnt;
    win_nxt  = win_cnt;
    if (pwm_s && (high_cnt != FULL_V)) begin
      high_nxt = high_cnt + DW'(1);
    end
    if (win_cnt != WIN_MAX) begin
      win_nxt = win_cnt + WW'(1);
    end
  end

  // The timeout fires on the cycle that would bring the window to 2*FULL, so a constant level repeats every 2*FULL clocks.
  assign timeout = (win_nxt == WIN_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      high_cnt   <= '0;
      win_cnt    <= '0;
      duty_meas  <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (rise) begin
        armed    <= 1'b1;
        high_cnt <= DW'(1);
        win_cnt  <= WW'(1);
        if (armed) begin
          duty_meas  <= high_cnt;
          duty_valid <= 1'b1;
        end
      end else if (timeout) begin
        armed      <= 1'b0;
        high_cnt   <= '0;
        win_cnt    <= '0;
        duty_meas  <= pwm_s ? FULL_V : '0;
        duty_valid <= 1'b1;
      end else begin
        high_cnt <= high_nxt;
        win_cnt  <= win_nxt;
      end
    end
  end

`ifdef FAN_EMU_STALL_EN
  assign frozen = stall;
`else
  assign frozen = 1'b0;
`endif

  assign target    = frozen ? '0 : duty_meas;
  assign ramp_tick = (div_cnt == DIV_LAST);

  // Speed walks one LSB per ramp tick toward the target. It compares against duty_meas as it was before any same-cycle update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      speed   <= '0;
    end else begin
      div_cnt <= ramp_tick ? '0 : div_cnt + DIV_W'(1);
      if (ramp_tick) begin
        if (speed < target) begin
          speed <= speed + DW'(1);
        end else if (speed > target) begin
          speed <= speed - DW'(1);
        end
      end
    end
  end

  assign phase_inc = PW'(speed) << INC_SHIFT;
  assign phase_sum = {1'b0, phase} + phase_inc;

  // Tach NCO: each phase wrap toggles tach_out. When speed is zero, the phase and the tach level hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      tach_out <= 1'b0;
    end else if (!frozen) begin
      phase <= phase_sum[PHASE_BITS-1:0];
      if (phase_sum[PHASE_BITS]) begin
        tach_out <= ~tach_out;
      end
    end
  end

endmodule

// File: tb/tb_fan_tach_emulator.sv
// Randomized self-checking bench for fan_tach_emulator. Two instances (RAMP_DIV 1 and 4) are compared to a window/accumulator model.
module tb_fan_tach_emulator;

  localparam int unsigned PWM_BITS   = 4;
  localparam int unsigned PHASE_BITS = 8;
  localparam int          FULL       = 16;
`ifdef FAN_EMU_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic                clock;
  logic                reset;
  logic                pwm_in;
`ifdef FAN_EMU_STALL_EN
  logic                stall;
`endif
  logic                tach0, tach1;
  logic                valid0, valid1;
  logic [PWM_BITS:0]   duty0, duty1, speed0, speed1;

  fan_tach_emulator #(.PWM_BITS(PWM_BITS), .PHASE_BITS(PHASE_BITS), .INC_SHIFT(0), .RAMP_DIV(1)) u_dut (
    .clock(clock), .reset(reset), .pwm_in(pwm_in),
`ifdef FAN_EMU_STALL_EN
    .stall(stall),
`endif
    .tach_out(tach0), .duty_meas(duty0), .duty_valid(valid0), .speed(speed0)
  );

  fan_tach_emulator #(.PWM_BITS(PWM_BITS), .PHASE_BITS(PHASE_BITS), .INC_SHIFT(0), .RAMP_DIV(4)) u_dut4 (
    .clock(clock), .reset(reset), .pwm_in(pwm_in),
`ifdef FAN_EMU_STALL_EN
    .stall(stall),
`endif
    .tach_out(tach1), .duty_meas(duty1), .duty_valid(valid1), .speed(speed1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  bit stall_lvl = 1'b0;

  // Reference model state
  bit     in_hist [3];   // pwm_in sampled 1, 2 and 3 edges ago
  bit     win [$];       // synchronized samples of the current window
  bit     m_armed;
  int     m_duty;
  bit     m_valid;
  int     m_spd [2];
  longint m_tot [2];     // unbounded phase: tach is bit PHASE_BITS of the running sum
  longint ncyc;

  function automatic int rd(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) in_hist[i] = 1'b0;
    win.delete();
    m_armed = 1'b0;
    m_duty  = 0;
    m_valid = 1'b0;
    ncyc    = 0;
    for (int i = 0; i < 2; i++) begin
      m_spd[i] = 0;
      m_tot[i] = 0;
    end
  endtask

  task automatic model_step(input bit p, input bit s);
    bit ps, pd, st;
    int tgt, hi;
    ps  = in_hist[1];
    pd  = in_hist[2];
    st  = HAS_STALL && s;
    tgt = st ? 0 : m_duty;
    for (int i = 0; i < 2; i++) begin
      if (!st) m_tot[i] += longint'(m_spd[i]);
      if ((ncyc % rd(i)) == rd(i) - 1) begin
        if (m_spd[i] < tgt) m_spd[i]++;
        else if (m_spd[i] > tgt) m_spd[i]--;
      end
    end
    ncyc++;
    m_valid = 1'b0;
    if (ps && !pd) begin
      if (m_armed) begin
        hi = 0;
        foreach (win[j]) hi += int'(win[j]);
        m_duty  = (hi > FULL) ? FULL : hi;
        m_valid = 1'b1;
      end
      m_armed = 1'b1;
      win.delete();
      win.push_back(1'b1);
    end else if (win.size() + 1 == 2 * FULL) begin
      m_duty  = ps ? FULL : 0;
      m_valid = 1'b1;
      m_armed = 1'b0;
      win.delete();
    end else begin
      win.push_back(ps);
    end
    in_hist[2] = in_hist[1];
    in_hist[1] = in_hist[0];
    in_hist[0] = p;
  endtask

  task automatic compare_all();
    check("valid_r1", int'(valid0), int'(m_valid));
    check("duty_r1",  int'(duty0),  m_duty);
    check("speed_r1", int'(speed0), m_spd[0]);
    check("tach_r1",  int'(tach0),  int'((m_tot[0] >> PHASE_BITS) & 1));
    check("valid_r4", int'(valid1), int'(m_valid));
    check("duty_r4",  int'(duty1),  m_duty);
    check("speed_r4", int'(speed1), m_spd[1]);
    check("tach_r4",  int'(tach1),  int'((m_tot[1] >> PHASE_BITS) & 1));
  endtask

  // One clock: drive after the falling edge, model at the rising edge, compare at the next falling edge
  task automatic step(input bit p);
    pwm_in = p;
`ifdef FAN_EMU_STALL_EN
    stall = stall_lvl;
`endif
    @(posedge clock);
    model_step(p, stall_lvl);
    @(negedge clock);
    compare_all();
  endtask

  task automatic run_pwm(input int hi, input int per, input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < per; c++) step(c < hi);
  endtask

  task automatic run_const(input bit lvl, input int n);
    for (int c = 0; c < n; c++) step(lvl);
  endtask

  // Reset asserted away from any clock edge. All outputs must clear before the next edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all();
    @(negedge clock);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    int per, hi, sel;
    reset  = 1'b1;
    pwm_in = 1'b0;
`ifdef FAN_EMU_STALL_EN
    stall  = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b0;

    run_const(1'b0, 80);      // periodic timeouts reporting 0
    run_pwm(8, 16, 14);       // 50% duty
    run_pwm(4, 16, 20);       // drop to 25%
    run_const(1'b1, 100);     // held high -> FULL on timeout
    run_pwm(10, 31, 6);       // rising edge lands on the timeout cycle
    run_pwm(20, 24, 6);       // window longer than FULL saturates

`ifdef FAN_EMU_STALL_EN
    run_pwm(8, 16, 4);
    stall_lvl = 1'b1;
    run_pwm(8, 16, 3);
    stall_lvl = 1'b0;
    run_pwm(8, 16, 4);
`endif

    async_reset();
    run_pwm(12, 16, 5);       // ramp 0 -> 12 in progress on the divided instance
    async_reset();
    run_pwm(12, 16, 6);

    for (int b = 0; b < 30; b++) begin
      sel = int'($urandom_range(0, 9));
      if (HAS_STALL) stall_lvl = ($urandom_range(0, 3) == 0);
      if (sel == 0) begin
        async_reset();
      end else if (sel == 1) begin
        run_const(1'($urandom_range(0, 1)), int'($urandom_range(40, 80)));
      end else begin
        per = int'($urandom_range(2, 40));
        hi  = int'($urandom_range(1, per - 1));
        run_pwm(hi, per, 120 / per + 1);
      end
    end
    stall_lvl = 1'b0;
    run_pwm(8, 16, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
